fwrisc_mem_arbiter: RTL and testbench
=====================================

Name: fwrisc_mem_arbiter

Overview:
- Merges the fwrisc core's separate instruction port (iaddr/idata/ivalid/iready) and data port (dvalid/daddr/dwdata/dwstb/dwrite/drdata/dready) onto one shared memory bus.
- Sits directly downstream of the core, between the core and the SoC memory/interconnect.
- Uses a registered request path, a registered response path and round-robin arbitration under contention.
- Handles one outstanding transaction at a time.

Parameters:
- TIMEOUT_CYCLES, 255, cycles waited for mready before forced completion (used only with FWRISC_ARB_TIMEOUT_EN; legal range 1..65535).

Ports:
- clock   in   1   clock
- reset   in   1   sync active-high reset
- iaddr   in   32  core fetch address
- ivalid  in   1   core fetch request, held until iready
- idata   out  32  fetch data, valid while iready=1
- iready  out  1   one-cycle fetch completion pulse
- daddr   in   32  core data address
- dwdata  in   32  core write data
- dwstb   in   4   core byte strobes
- dwrite  in   1   1=store, 0=load
- dvalid  in   1   core data request, held until dready
- drdata  out  32  load data, valid while dready=1
- dready  out  1   one-cycle data completion pulse
- maddr   out  32  memory address
- mwdata  out  32  memory write data
- mwstb   out  4   memory strobes
- mwrite  out  1   memory write enable
- mvalid  out  1   memory request, held until mready
- mrdata  in   32  memory read data, valid with mready
- mready  in   1   memory completion
- merr    out  1   one-cycle timeout error pulse

Behaviour:
- Reset (synchronous, active-high, clock rising edge):
  - state=IDLE, last_grant=I.
  - mvalid, iready, dready, merr = 0.
  - maddr, mwdata, mwstb, mwrite, idata, drdata = 0.
- States: IDLE, IBUS, DBUS, RESP.
- IDLE:
  - Only dvalid: latch daddr/dwdata/dwstb/dwrite into m* registers; go DBUS; last_grant<=D.
  - Only ivalid: latch iaddr; mwrite=0, mwstb=0, mwdata=0; go IBUS; last_grant<=I.
  - Both asserted: grant the port opposite last_grant. First contention after reset goes to D.
  - Neither asserted: stay.
- IBUS/DBUS:
  - mvalid=1; m* outputs held stable.
  - On mready=1: capture mrdata into the response register, deassert mvalid next cycle, go RESP.
- RESP (exactly one cycle):
  - Assert iready (if from IBUS) or dready (if from DBUS) with idata/drdata = captured data.
  - For stores, drdata = captured mrdata (don't-care for core).
  - Then go IDLE.
- idata/drdata hold their last value outside RESP.
- Latency with mready in the first mvalid cycle: request accepted at cycle N, mvalid at N+1, mready at N+1, ready pulse at N+2, IDLE at N+3. Minimum 3 cycles per transaction; no back-to-back overlap.
- mready while mvalid=0 is ignored.
- A core request that drops before grant is not captured.
- A request sampled in IDLE the cycle after a ready pulse is treated as new. The core must have dropped valid after ready.
- Reset mid-transaction: next cycle mvalid=0 and no ready pulse is ever issued; the memory side must tolerate the abandoned request.
- iready and dready are never asserted in the same cycle.

Optional Feature:
- Macro FWRISC_ARB_TIMEOUT_EN.
- Enabled:
  - A 16-bit counter clears on entry to IBUS/DBUS and increments each cycle mvalid=1 && mready=0.
  - When the count reaches TIMEOUT_CYCLES: drop mvalid, go RESP with response data 32'h00000000, and assert merr for the same cycle as the ready pulse.
  - A late mready after timeout is ignored.
- Disabled: no counter; merr tied 0; the arbiter waits forever for mready.

Test Plan:
- Fetch only: ivalid=1, iaddr=0x100, memory returns mrdata=0x00000013 with mready at the first mvalid cycle -> maddr=0x100, mwrite=0; iready pulse two cycles after accept; idata=0x00000013.
- Store: dvalid=1, dwrite=1, daddr=0x2000, dwdata=0xDEADBEEF, dwstb=4'b0011, mready after 3 wait cycles -> m* match inputs for all 4 mvalid cycles; single dready pulse; iready stays 0.
- Contention: ivalid and dvalid both asserted from reset, ivalid re-raised after each completion, dvalid re-raised -> grant order D, I, D, I; neither port starved.
- Reset mid-op: assert reset for one cycle during DBUS with mready=0 -> mvalid=0 next cycle; no dready pulse; state IDLE; idata/drdata=0.
- Timeout (macro on, TIMEOUT_CYCLES=4): ivalid=1 with mready held 0 -> mvalid high 4 cycles then low; iready and merr pulse together; idata=0; a later stray mready has no effect.
- Spurious mready: mready=1 in IDLE with no requests -> no ready pulses, outputs unchanged.

Source files
------------

// File: rtl/fwrisc_mem_arbiter.sv
// fwrisc_mem_arbiter
// Merges the core's instruction and data ports onto one shared memory bus.
// One transaction in flight at a time; round-robin between ports when both
// request in the same IDLE cycle (first contention after reset goes to data).
// Optional: define FWRISC_ARB_TIMEOUT_EN to force completion (data 0, merr
// pulse) after TIMEOUT_CYCLES cycles of mvalid without mready.
module fwrisc_mem_arbiter #(
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [31:0] iaddr,
   input  logic        ivalid,
   output logic [31:0] idata,
   output logic        iready,
   input  logic [31:0] daddr,
   input  logic [31:0] dwdata,
   input  logic [3:0]  dwstb,
   input  logic        dwrite,
   input  logic        dvalid,
   output logic [31:0] drdata,
   output logic        dready,
   output logic [31:0] maddr,
   output logic [31:0] mwdata,
   output logic [3:0]  mwstb,
   output logic        mwrite,
   output logic        mvalid,
   input  logic [31:0] mrdata,
   input  logic        mready,
   output logic        merr
);

   typedef enum logic [1:0] {IDLE, IBUS, DBUS, RESP} state_t;

   state_t state, state_nxt;
   logic   last_d;     // last grant went to the data port
   logic   resp_d;     // transaction in flight belongs to the data port
   logic   grant_d, grant_i;
   logic   on_bus;
   logic   timed_out;

   // data wins if it is alone, or if instruction port had the last grant
   assign grant_d = dvalid && (!ivalid || !last_d);
   assign grant_i = ivalid && !grant_d;
   assign on_bus  = (state == IBUS) || (state == DBUS);

`ifdef FWRISC_ARB_TIMEOUT_EN
   localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);
   logic [15:0] to_cnt;
   logic        to_flag;

   // this cycle is the last one we are willing to wait for mready
   assign timed_out = on_bus && !mready && (to_cnt == TO_LAST);

   // wait-cycle counter: cleared while idle, counts unanswered bus cycles
   always_ff @(posedge clock) begin
      if (reset || state == IDLE) to_cnt <= '0;
      else if (on_bus && !mready) to_cnt <= to_cnt + 16'd1;
   end

   // remembers that the pending response is a forced (timeout) completion
   always_ff @(posedge clock) begin
      if (reset) to_flag <= 1'b0;
      else if (on_bus) to_flag <= timed_out;
   end
`else
   assign timed_out = 1'b0;
`endif

   // state register
   always_ff @(posedge clock) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   // next-state: grant in IDLE, wait for completion on the bus, one RESP cycle
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (grant_d)      state_nxt = DBUS;
            else if (grant_i) state_nxt = IBUS;
         end
         IBUS, DBUS: if (mready || timed_out) state_nxt = RESP;
         RESP:       state_nxt = IDLE;
         default:    state_nxt = IDLE;
      endcase
   end

   // handshake outputs decoded from the state register
   always_comb begin
      mvalid = on_bus;
      iready = (state == RESP) && !resp_d;
      dready = (state == RESP) &&  resp_d;
`ifdef FWRISC_ARB_TIMEOUT_EN
      merr   = (state == RESP) && to_flag;
`else
      merr   = 1'b0;
`endif
   end

   // request capture on grant, response capture on completion
   always_ff @(posedge clock) begin
      if (reset) begin
         last_d <= 1'b0;
         resp_d <= 1'b0;
         maddr  <= '0;
         mwdata <= '0;
         mwstb  <= '0;
         mwrite <= 1'b0;
         idata  <= '0;
         drdata <= '0;
      end else begin
         if (state == IDLE) begin
            if (grant_d) begin
               maddr  <= daddr;
               mwdata <= dwdata;
               mwstb  <= dwstb;
               mwrite <= dwrite;
               last_d <= 1'b1;
               resp_d <= 1'b1;
            end else if (grant_i) begin
               maddr  <= iaddr;
               mwdata <= '0;
               mwstb  <= '0;
               mwrite <= 1'b0;
               last_d <= 1'b0;
               resp_d <= 1'b0;
            end
         end else if (on_bus && (mready || timed_out)) begin
            // a real response takes priority over a timeout in the same cycle
            if (resp_d) drdata <= mready ? mrdata : 32'h0;
            else        idata  <= mready ? mrdata : 32'h0;
         end
      end
   end

endmodule

// File: tb/tb_fwrisc_mem_arbiter.sv
// Self-checking bench for fwrisc_mem_arbiter: a random core + random-latency
// memory driven against a transaction-level model of the arbitration rules,
// followed by directed reset-mid-op and wait/timeout scenarios.
module tb_fwrisc_mem_arbiter;

   logic        clock = 1'b0;
   logic        reset;
   logic [31:0] iaddr, idata, daddr, dwdata, drdata, maddr, mwdata, mrdata;
   logic [3:0]  dwstb, mwstb;
   logic        ivalid, iready, dwrite, dvalid, dready, mwrite, mvalid, mready, merr;

   fwrisc_mem_arbiter #(.TIMEOUT_CYCLES(4)) dut (
      .clock(clock), .reset(reset),
      .iaddr(iaddr), .ivalid(ivalid), .idata(idata), .iready(iready),
      .daddr(daddr), .dwdata(dwdata), .dwstb(dwstb), .dwrite(dwrite),
      .dvalid(dvalid), .drdata(drdata), .dready(dready),
      .maddr(maddr), .mwdata(mwdata), .mwstb(mwstb), .mwrite(mwrite),
      .mvalid(mvalid), .mrdata(mrdata), .mready(mready), .merr(merr)
   );

   always #5 clock = ~clock;

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   // model of the previous cycle: arbiter idle / on bus / responding
   bit          pfree, pbus, presp, hs_prev, ppi, ppd;
   bit          last_d, gd;
   int          wait_cnt, n_gi, n_gd;
   logic [31:0] e_addr, e_wdata, e_data, e_idata, e_drdata;
   logic [3:0]  e_wstb;
   logic        e_wr;

   // one cycle: check what the DUT shows, then drive core + memory
   task automatic step(input bit allow_new);
      bit cur_resp, cur_bus, cur_free, hs;
      @(negedge clock);
      cur_resp = hs_prev;
      cur_bus  = (pfree && (ppi || ppd)) || (pbus && !hs_prev);
      cur_free = presp || (pfree && !(ppi || ppd));
      if (cur_bus && !pbus) begin
         // round robin: data if alone or if instruction had the last grant
         gd = ppd && (!ppi || !last_d);
         last_d = gd;
         if (gd) begin
            n_gd++; e_addr = daddr; e_wdata = dwdata; e_wstb = dwstb; e_wr = dwrite;
         end else begin
            n_gi++; e_addr = iaddr; e_wdata = 0; e_wstb = 0; e_wr = 0;
         end
         wait_cnt = $urandom_range(3, 0);
      end
      if (cur_resp) begin
         if (gd) e_drdata = e_data; else e_idata = e_data;
      end
      chk("mvalid", mvalid, cur_bus);
      if (cur_bus) begin
         chk("maddr", maddr, e_addr);
         chk("mwdata", mwdata, e_wdata);
         chk("mwstb", mwstb, e_wstb);
         chk("mwrite", mwrite, e_wr);
      end
      chk("iready", iready, cur_resp && !gd);
      chk("dready", dready, cur_resp && gd);
      chk("idata", idata, e_idata);
      chk("drdata", drdata, e_drdata);
      chk("merr", merr, 0);
      // memory
      hs = 0;
      mrdata = $urandom;
      if (cur_bus) begin
         if (wait_cnt == 0) begin mready = 1; e_data = mrdata; hs = 1; end
         else begin mready = 0; wait_cnt--; end
      end else mready = ($urandom_range(3, 0) == 0);   // spurious, must be ignored
      // core: drop on completion, maybe raise a new request
      if (cur_resp && !gd) ivalid = 0;
      if (cur_resp &&  gd) dvalid = 0;
      if (allow_new && !ivalid && $urandom_range(1, 0) == 1) begin
         ivalid = 1; iaddr = $urandom & 32'hFFFF_FFFC;
      end
      if (allow_new && !dvalid && $urandom_range(1, 0) == 1) begin
         dvalid = 1; daddr = $urandom; dwdata = $urandom;
         dwstb = 4'($urandom); dwrite = 1'($urandom);
      end
      pfree = cur_free; pbus = cur_bus; presp = cur_resp; hs_prev = hs;
      ppi = ivalid; ppd = dvalid;
   endtask

   initial begin
      int n;
      reset = 1; ivalid = 0; dvalid = 0; iaddr = 0; daddr = 0; dwdata = 0;
      dwstb = 0; dwrite = 0; mrdata = 0; mready = 0;
      repeat (2) @(posedge clock);
      @(negedge clock);
      chk("rst_mvalid", mvalid, 0);
      chk("rst_iready", iready, 0);
      chk("rst_dready", dready, 0);
      chk("rst_maddr", maddr, 0);
      chk("rst_idata", idata, 0);
      chk("rst_drdata", drdata, 0);
      // contention straight out of reset: fetch 0x100 vs store 0x2000
      reset = 0;
      ivalid = 1; iaddr = 32'h100;
      dvalid = 1; daddr = 32'h2000; dwdata = 32'hDEADBEEF; dwstb = 4'b0011; dwrite = 1;
      pfree = 1; pbus = 0; presp = 0; hs_prev = 0; ppi = 1; ppd = 1;
      last_d = 0; gd = 0; n_gi = 0; n_gd = 0; e_idata = 0; e_drdata = 0;
      for (int i = 0; i < 600; i++) step(1);
      n = 0;
      while (!(pfree && !ivalid && !dvalid) && n < 60) begin step(0); n++; end
      chk("drained", n < 60, 1);
      chk("grants_i_seen", n_gi > 20, 1);
      chk("grants_d_seen", n_gd > 20, 1);

      // reset while a load is waiting on the bus
      dvalid = 1; daddr = 32'h44; dwrite = 0; mready = 0;
      n = 0;
      do begin @(negedge clock); n++; end while (!mvalid && n < 5);
      chk("rst_op_mvalid_up", mvalid, 1);
      reset = 1; dvalid = 0;
      @(negedge clock);
      reset = 0; mready = 1;                            // stray mready in IDLE
      chk("rst_op_mvalid", mvalid, 0);
      chk("rst_op_dready", dready, 0);
      chk("rst_op_idata", idata, 0);
      chk("rst_op_drdata", drdata, 0);
      for (int i = 0; i < 4; i++) begin
         @(negedge clock);
         chk("idle_mvalid", mvalid, 0);
         chk("idle_ready", {iready, dready}, 0);
         chk("idle_drdata", drdata, 0);
      end
      mready = 0;

      // fetch with memory silent
      ivalid = 1; iaddr = 32'h300;
      n = 0;
      do begin @(negedge clock); n++; end while (!mvalid && n < 5);
      chk("to_mvalid_up", mvalid, 1);
`ifdef FWRISC_ARB_TIMEOUT_EN
      n = 0;
      while (mvalid && n < 12) begin n++; @(negedge clock); end
      chk("to_cycles", n, 4);
      chk("to_iready", iready, 1);
      chk("to_merr", merr, 1);
      chk("to_idata", idata, 0);
      ivalid = 0; mready = 1; mrdata = 32'h1234;           // late mready
      @(negedge clock);
      chk("to_late_ready", {iready, dready, merr, mvalid}, 0);
      @(negedge clock);
      chk("to_late_ready2", {iready, dready, merr, mvalid}, 0);
      chk("to_late_idata", idata, 0);
      mready = 0;
`else
      repeat (8) @(negedge clock);
      chk("wait_mvalid", mvalid, 1);
      chk("wait_merr", merr, 0);
      chk("wait_iready", iready, 0);
      mready = 1; mrdata = 32'h13;
      @(negedge clock);
      mready = 0;
      chk("wait_iready_done", iready, 1);
      chk("wait_idata", idata, 32'h13);
      chk("wait_merr_done", merr, 0);
      ivalid = 0;
      @(negedge clock);
      chk("wait_after", {iready, mvalid}, 0);
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
